fetch_unit: RTL

- Instruction-fetch front end for the tinylab CPU; the requester side of the instruction-ROM interface.
- Drives the ROM address and read request, and accepts the data/valid returned by the ROM in the same cycle.
- Registers each fetched word into an instruction register (IR) and presents it to decode with a valid/ready handshake.
- Owns the program counter (PC): sequential increment, wrap at DEPTH, and jump redirect from execute.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_pc_next.sv | 27 ++
 rtl/fetch_unit.sv | 71 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared tinylab CPU definitions: fetch FSM states and default bus/ROM geometry.
package cpu_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned AWIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selector: redirect wins, then sequential increment with wrap at DEPTH, else hold.
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic [AWIDTH-1:0] pc,
  input  logic              redirect_en,
  input  logic [AWIDTH-1:0] redirect_addr,
  input  logic              fetch_fire,
  output logic [AWIDTH-1:0] next_pc
);

  localparam logic [AWIDTH-1:0] LAST_PC = AWIDTH'(DEPTH - 1);

  always_comb begin
    next_pc = pc;
    if (redirect_en) begin
      next_pc = redirect_addr;
    end else if (fetch_fire) begin
      // Out-of-range targets never equal LAST_PC, so they count up to AWIDTH overflow.
      next_pc = (pc == LAST_PC) ? '0 : pc + AWIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, requests ROM words and holds them in the IR
// behind a valid/ready handshake to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DWIDTH   = DWIDTH_DEF,
  parameter int unsigned AWIDTH   = AWIDTH_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_ready,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              mem_valid,
  input  logic              redirect_en,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  fetch_state_t      state;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] next_pc;
  logic              fetch_fire;

  assign mem_addr = pc;

  // A new request may issue in the same cycle the IR drains, giving one word per cycle.
  assign mem_ready = !rst && (state == FETCH) && enable && !redirect_en
                     && (!instr_valid || instr_ready);
  assign fetch_fire = mem_ready && mem_valid;

  fetch_pc_next #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_pc_next (
    .pc            (pc),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .fetch_fire    (fetch_fire),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= AWIDTH'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= enable ? FETCH : IDLE;
      pc    <= next_pc;
      if (redirect_en) begin
        instr_valid <= 1'b0;
      end else if (fetch_fire) begin
        instr       <= mem_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
